dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port. It serves single LW/SW accesses and LM/SM multi-register bursts.
- Owns the data storage array. Inserts a configurable wait-state latency per beat. Returns read data and write acknowledgements over a valid/ready response channel.
- Burst beats walk the 8-bit register mask lowest-bit-first, one memory word per set bit, with ascending addresses.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_mask_scan.sv | 25 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its mask scanner.
package dmem_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned MASK_W    = 8;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WDATA,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_mask_scan.sv
// Lowest-set-bit priority encoder over the remaining burst mask, plus none-left
// and is-last flags.
module dmem_mask_scan
    import dmem_pkg::*;
(
    input  logic [MASK_W-1:0]    mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 none,
    output logic                 last
);

    always_comb begin
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = REG_IDX_W'(i);
            end
        end
    end

    assign none = (mask == '0);
    // At most one bit set means nothing remains above the current beat.
    assign last = ((mask & (mask - MASK_W'(1))) == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single LW/SW and LM/SM bursts with per-beat wait states.
// Optional address range checking is enabled with `define DMEM_RANGE_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_multi,
    input  logic [WORD_W-1:0]    req_addr,
    input  logic [WORD_W-1:0]    req_wdata,
    input  logic [MASK_W-1:0]    req_mask,
    input  logic                 wd_valid,
    output logic                 wd_ready,
    input  logic [WORD_W-1:0]    wd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_W-1:0]    rsp_data,
    output logic [REG_IDX_W-1:0] rsp_reg,
    output logic                 rsp_last,
    output logic                 rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t              state;
    logic                we_q;
    logic                multi_q;
    logic [WORD_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   mask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic [REG_IDX_W-1:0] scan_idx;
    logic                 scan_none;
    logic                 scan_last;

    dmem_mask_scan u_mask_scan (
        .mask (mask_q),
        .idx  (scan_idx),
        .none (scan_none),
        .last (scan_last)
    );

    logic [IDX_W-1:0] word_idx;
    logic             unused_addr_hi;
    logic             addr_err;
    logic             skip;
    logic             beat_last;
    logic [REG_IDX_W-1:0] beat_reg;

    assign word_idx       = addr_q[IDX_W-1:0];
    assign unused_addr_hi = ^(addr_q >> IDX_W);

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_err = ({1'b0, addr_q} >= 17'(DEPTH));
`else
    assign addr_err = 1'b0;
`endif

    // An empty burst mask or an out-of-range beat touches no memory.
    assign skip      = (multi_q && scan_none) || addr_err;
    assign beat_last = !multi_q || scan_last;
    assign beat_reg  = multi_q ? scan_idx : '0;
    assign req_ready = (state == IDLE) && !reset;

    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (!reset) begin
            if (state == WAIT && cnt_q == '0 && we_q && !multi_q && !skip) begin
                mem_we = 1'b1;
            end
            if (state == WDATA && wd_valid) begin
                mem_we    = 1'b1;
                mem_wdata = wd_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            multi_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            wd_ready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_reg   <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        multi_q <= req_multi;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        mask_q  <= req_mask;
                        // A zero count makes the first WAIT cycle the access step.
                        cnt_q   <= CNT_W'(LATENCY);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_reg  <= beat_reg;
                        rsp_last <= beat_last;
                        rsp_err  <= addr_err;
                        rsp_data <= (!skip && !we_q) ? mem[word_idx] : '0;
                        if (we_q && multi_q && !skip) begin
                            wd_ready <= 1'b1;
                            state    <= WDATA;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WDATA: begin
                    if (wd_valid) begin
                        wd_ready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            mask_q <= mask_q & (mask_q - MASK_W'(1));
                            addr_q <= addr_q + WORD_W'(1);
                            cnt_q  <= CNT_W'(LATENCY);
                            state  <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a beat-list memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 1;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // {data, reg, last, err}
    typedef logic [20:0] beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_multi = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [7:0]  req_mask = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [15:0] wd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_reg;
    logic        rsp_last;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_multi (req_multi),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_reg   (rsp_reg),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] wd_src [$];
    beat_t       exp_beats [$];
    beat_t       got_beats [$];
    int          exp_wd_beats;
    int          wd_cycles;
    int          first_rsp;
    bit          beat_stable;
    bit          busy_ready;

    // Expected beats straight from the access rules: one beat per set mask bit,
    // ascending addresses, writes consuming store data in order.
    function automatic void model_req(input logic we, input logic multi, input logic [15:0] addr,
                                      input logic [15:0] wdata, input logic [7:0] mask);
        int          bits [$];
        int          wi;
        logic [15:0] a;
        logic [15:0] d;
        bit          err;
        exp_beats.delete();
        exp_wd_beats = 0;
        wi = 0;
        if (!multi) bits.push_back(0);
        else for (int i = 0; i < 8; i++) if (mask[i]) bits.push_back(i);
        if (bits.size() == 0) begin
            exp_beats.push_back({16'h0000, 3'd0, 1'b1, 1'b0});
            return;
        end
        foreach (bits[k]) begin
            a   = addr + 16'(k);
            err = RANGE_EN && (int'(a) >= int'(DEPTH));
            d   = 16'h0000;
            if (!err) begin
                if (!we) d = model_mem[int'(a) % DEPTH];
                else if (!multi) model_mem[int'(a) % DEPTH] = wdata;
                else begin
                    model_mem[int'(a) % DEPTH] = wd_src[wi];
                    wi++;
                    exp_wd_beats++;
                end
            end
            exp_beats.push_back({d, 3'(bits[k]), k == bits.size() - 1, err});
        end
    endfunction

    // Drives one request and collects its response beats (bounded in cycles).
    task automatic run_req(input logic we, input logic multi, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [7:0] mask,
                           input int wd_stall, input int rsp_stall);
        int          cyc;
        int          wd_cnt;
        int          rsp_cnt;
        bit          done;
        logic [15:0] hd;
        logic [2:0]  hr;
        logic        hl;
        got_beats.delete();
        wd_cycles   = 0;
        first_rsp   = -1;
        beat_stable = 1'b1;
        busy_ready  = 1'b0;
        hd = '0; hr = '0; hl = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_multi = multi;
        req_addr = addr; req_wdata = wdata; req_mask = mask;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0; done = 1'b0; wd_cnt = 0; rsp_cnt = 0;
        while (!done && cyc < 400) begin
            wd_valid  = 1'b0;
            rsp_ready = 1'b0;
            if (req_ready) busy_ready = 1'b1;
            if (wd_ready) begin
                wd_cycles++;
                if (wd_cnt < wd_stall) wd_cnt++;
                else begin
                    wd_valid = 1'b1;
                    wd_data  = (wd_src.size() > 0) ? wd_src.pop_front() : 16'h0000;
                    wd_cnt   = 0;
                end
            end
            if (rsp_valid) begin
                if (first_rsp < 0) first_rsp = cyc;
                if (rsp_cnt == 0) begin
                    hd = rsp_data; hr = rsp_reg; hl = rsp_last;
                end else if (rsp_data !== hd || rsp_reg !== hr || rsp_last !== hl) begin
                    beat_stable = 1'b0;
                end
                if (rsp_cnt < rsp_stall) rsp_cnt++;
                else begin
                    rsp_ready = 1'b1;
                    got_beats.push_back({rsp_data, rsp_reg, rsp_last, rsp_err});
                    rsp_cnt = 0;
                    if (rsp_last) done = 1'b1;
                end
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        wd_valid  = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout addr=%h got_beats=%0d required=last beat", addr, got_beats.size());
        end
    endtask

    task automatic do_txn(input logic we, input logic multi, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [7:0] mask,
                          input int wd_stall, input int rsp_stall);
        model_req(we, multi, addr, wdata, mask);
        run_req(we, multi, addr, wdata, mask, wd_stall, rsp_stall);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({req_ready, wd_ready, rsp_valid, rsp_last, rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {req_ready, wd_ready, rsp_valid, rsp_last, rsp_err});
        end
        checks++;
        if ({rsp_data, rsp_reg} !== 19'h0) begin
            errors++;
            $display("FAIL reset_data got=%h/%0d required=0/0", rsp_data, rsp_reg);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b required=1", req_ready);
        end
    endtask

    task automatic test_fill();
        logic [15:0] w;
        for (int a = 0; a < int'(DEPTH); a++) begin
            w = 16'($urandom);
            do_txn(1'b1, 1'b0, 16'(a), w, 8'h00, 0, 0);
            checks++;
            if (got_beats.size() != 1 || got_beats[0] !== exp_beats[0]) begin
                errors++;
                $display("FAIL fill_ack addr=%h got=%h required=%h", a, got_beats[0], exp_beats[0]);
            end
        end
    endtask

    task automatic test_single_rw();
        do_txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, 8'h00, 0, 0);
        checks++;
        if (got_beats.size() != 1 || got_beats[0] !== {16'h0000, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sw_ack got=%h required=%h", got_beats[0], {16'h0000, 3'd0, 1'b1, 1'b0});
        end
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats.size() != 1 || got_beats[0] !== {16'hBEEF, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lw_data got=%h required=%h", got_beats[0], {16'hBEEF, 3'd0, 1'b1, 1'b0});
        end
        checks++;
        if (first_rsp != 1 + int'(LATENCY)) begin
            errors++;
            $display("FAIL lw_latency got=%0d required=%0d", first_rsp, 1 + LATENCY);
        end
        checks++;
        if (busy_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got=1 required=0");
        end
    endtask

    task automatic test_random_single();
        logic        we;
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom);
            a  = (n % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            do_txn(we, 1'b0, a, 16'($urandom), 8'h00, 0, 0);
            checks++;
            if (got_beats.size() != 1 || got_beats[0] !== exp_beats[0]) begin
                errors++;
                $display("FAIL single%0d we=%b addr=%h got=%h required=%h",
                         n, we, a, got_beats[0], exp_beats[0]);
            end
        end
    endtask

    task automatic test_lm_burst();
        beat_t want [3];
        do_txn(1'b1, 1'b0, 16'h0020, 16'h1111, 8'h00, 0, 0);
        do_txn(1'b1, 1'b0, 16'h0021, 16'h2222, 8'h00, 0, 0);
        do_txn(1'b1, 1'b0, 16'h0022, 16'h3333, 8'h00, 0, 0);
        want[0] = {16'h1111, 3'd0, 1'b0, 1'b0};
        want[1] = {16'h2222, 3'd2, 1'b0, 1'b0};
        want[2] = {16'h3333, 3'd7, 1'b1, 1'b0};
        do_txn(1'b0, 1'b1, 16'h0020, 16'h0000, 8'b1000_0101, 0, 0);
        checks++;
        if (got_beats.size() != 3) begin
            errors++;
            $display("FAIL lm_count got=%0d required=3", got_beats.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= got_beats.size() || got_beats[k] !== want[k]) begin
                errors++;
                $display("FAIL lm_beat%0d got=%h required=%h", k, got_beats[k], want[k]);
            end
        end
    endtask

    task automatic test_sm_stall();
        logic [15:0] d1;
        logic [15:0] d2;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        wd_src.delete();
        wd_src.push_back(d1);
        wd_src.push_back(d2);
        do_txn(1'b1, 1'b1, 16'hFFFF, 16'h0000, 8'b0000_0110, 5, 0);
        checks++;
        if (got_beats.size() != exp_beats.size()) begin
            errors++;
            $display("FAIL sm_count got=%0d required=%0d", got_beats.size(), exp_beats.size());
        end
        foreach (exp_beats[k]) begin
            checks++;
            if (k >= got_beats.size() || got_beats[k] !== exp_beats[k]) begin
                errors++;
                $display("FAIL sm_ack%0d got=%h required=%h", k, got_beats[k], exp_beats[k]);
            end
        end
        checks++;
        if (wd_cycles != exp_wd_beats * 6) begin
            errors++;
            $display("FAIL sm_wdata_hold got=%0d required=%0d", wd_cycles, exp_wd_beats * 6);
        end
        do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL sm_rd_ffff got=%h required=%h", got_beats[0], exp_beats[0]);
        end
        do_txn(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL sm_rd_wrap got=%h required=%h", got_beats[0], exp_beats[0]);
        end
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 1'b1, 16'($urandom_range(0, 200)), 16'h0000, 8'b0101_1001, 0, 4);
        checks++;
        if (beat_stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable got=0 required=1");
        end
        foreach (exp_beats[k]) begin
            checks++;
            if (k >= got_beats.size() || got_beats[k] !== exp_beats[k]) begin
                errors++;
                $display("FAIL bp_beat%0d got=%h required=%h", k, got_beats[k], exp_beats[k]);
            end
        end
    endtask

    task automatic test_mask_zero();
        wd_src.delete();
        wd_src.push_back(16'hDEAD);
        do_txn(1'b1, 1'b1, 16'h0033, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats.size() != 1 || got_beats[0] !== {16'h0000, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sm_zero got=%h required=%h", got_beats[0], {16'h0000, 3'd0, 1'b1, 1'b0});
        end
        checks++;
        if (wd_cycles != 0) begin
            errors++;
            $display("FAIL sm_zero_wd got=%0d required=0", wd_cycles);
        end
        do_txn(1'b0, 1'b1, 16'h0033, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats.size() != 1 || got_beats[0] !== {16'h0000, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lm_zero got=%h required=%h", got_beats[0], {16'h0000, 3'd0, 1'b1, 1'b0});
        end
        do_txn(1'b0, 1'b0, 16'h0033, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL zero_nochange got=%h required=%h", got_beats[0], exp_beats[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] d1;
        int          cyc;
        d1 = 16'($urandom);
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_multi = 1'b1;
        req_addr = 16'h0040; req_mask = 8'b0000_0011;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0;
        while (!wd_ready && cyc < 50) begin @(negedge clock); cyc++; end
        wd_valid = 1'b1; wd_data = d1;
        @(negedge clock);
        wd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin @(negedge clock); cyc++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_beat1 got=%b/%b required=1/0", rsp_valid, rsp_last);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        model_mem[8'h40] = d1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({req_ready, wd_ready, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_hold got=%b required=000", {req_ready, wd_ready, rsp_valid});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_idle got=%b required=1", req_ready);
        end
        wd_valid = 1'b1; wd_data = ~d1;
        repeat (4) @(negedge clock);
        wd_valid = 1'b0;
        do_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL rst_kept got=%h required=%h", got_beats[0], exp_beats[0]);
        end
        do_txn(1'b0, 1'b0, 16'h0041, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL rst_dropped got=%h required=%h", got_beats[0], exp_beats[0]);
        end
    endtask

    task automatic test_alias();
        do_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h00, 0, 0);
        checks++;
        if (got_beats[0] !== exp_beats[0]) begin
            errors++;
            $display("FAIL alias_0100 got=%h required=%h", got_beats[0], exp_beats[0]);
        end
    endtask

    task automatic test_random_bursts();
        logic        we;
        logic [15:0] a;
        logic [7:0]  m;
        int          ws;
        for (int n = 0; n < 16; n++) begin
            we = 1'($urandom);
            a  = (n % 3 == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                              : 16'($urandom_range(0, DEPTH - 1));
            m  = 8'($urandom);
            ws = $urandom_range(0, 3);
            wd_src.delete();
            for (int i = 0; i < 8; i++) wd_src.push_back(16'($urandom));
            do_txn(we, 1'b1, a, 16'h0000, m, ws, $urandom_range(0, 2));
            checks++;
            if (got_beats.size() != exp_beats.size()) begin
                errors++;
                $display("FAIL burst%0d_count got=%0d required=%0d",
                         n, got_beats.size(), exp_beats.size());
            end
            foreach (exp_beats[k]) begin
                checks++;
                if (k >= got_beats.size() || got_beats[k] !== exp_beats[k]) begin
                    errors++;
                    $display("FAIL burst%0d_beat%0d got=%h required=%h",
                             n, k, got_beats[k], exp_beats[k]);
                end
            end
            checks++;
            if (wd_cycles != exp_wd_beats * (ws + 1)) begin
                errors++;
                $display("FAIL burst%0d_wd got=%0d required=%0d",
                         n, wd_cycles, exp_wd_beats * (ws + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_rw();
        test_lm_burst();
        test_sm_stall();
        test_backpressure();
        test_mask_zero();
        test_reset_mid_burst();
        test_alias();
        test_random_bursts();
        test_random_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
